// File: rtl/memory_stage_pkg.sv
// Shared definitions for the RV32i memory stage: writeback-mux encodings,
// load/store funct3 codes and the data-memory access FSM states.
// Ports: none (package).
package memory_stage_pkg;

  // Writeback result mux select, shared with the writeback stage.
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // Load/store funct3 encodings. Bits [1:0] give the access size,
  // bit 2 selects zero-extension for loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size field (funct3[1:0]).
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage and data memory.
// master: drives request, write enable, word address, lane enables and data.
// slave:  returns ready (access completes this cycle) and the read word.
interface memory_stage_if;

  logic        DMem_Req;
  logic        DMem_We;
  logic [31:0] DMem_Addr;
  logic [3:0]  DMem_Byte_En;
  logic [31:0] DMem_Wdata;
  logic        DMem_Ready;
  logic [31:0] DMem_Rdata;

  modport master (
    output DMem_Req,
    output DMem_We,
    output DMem_Addr,
    output DMem_Byte_En,
    output DMem_Wdata,
    input  DMem_Ready,
    input  DMem_Rdata
  );

  modport slave (
    input  DMem_Req,
    input  DMem_We,
    input  DMem_Addr,
    input  DMem_Byte_En,
    input  DMem_Wdata,
    output DMem_Ready,
    output DMem_Rdata
  );

endinterface

// File: rtl/memory_stage_load_store_align.sv
// load_store_align: lane steering for byte/half/word accesses.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: mem_read/mem_write/funct3/addr_lo describe the access; store_data in,
//   byte_en/wdata out for stores; rdata in, load_ext out for loads;
//   misaligned flags bad alignment or an illegal funct3 for the access type.
module load_store_align
  import memory_stage_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_ext
);

  logic        legal;
  logic        bad_align;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Loads take priority when both read and write are raised, so the load
  // table decides legality in that case.
  always_comb begin
    legal = 1'b0;
    if (mem_read) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end else if (mem_write) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
  end

  always_comb begin
    bad_align = 1'b0;
    case (funct3[1:0])
      SIZE_H:  bad_align = addr_lo[0];
      SIZE_W:  bad_align = (addr_lo != 2'b00);
      default: bad_align = 1'b0;
    endcase
  end

  // An illegal funct3 is reported as a misaligned access.
  assign misaligned = (mem_read | mem_write) & (~legal | bad_align);

  // Store side: lane enables and lane-replicated data.
  always_comb begin
    byte_en = 4'b1111;
    wdata   = store_data;
    case (funct3[1:0])
      SIZE_B: begin
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        byte_en = 4'b0011 << addr_lo;
        wdata   = {2{store_data[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = store_data;
      end
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
  end

  // Halfwords only ever sit at lane 0 or lane 2 when aligned.
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_ext = rdata;
    case (funct3)
      F3_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_ext = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_ext = {24'd0, byte_lane};
      F3_HU:   load_ext = {16'd0, half_lane};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: RV32i M stage; issues data-memory accesses and holds MEM/WB.
// Latency: one cycle to W; zero extra when DMem_Ready is high on request.
// Backpressure: Stall_M holds upstream while DMem_Ready is low; gives up
//   after MAX_WAIT wait cycles with a Bus_Timeout_M pulse and a W bubble.
// Ports: CLK/RST (sync, active-high); *_M pipeline inputs from EX/MEM;
//   dmem data-memory bus (master); Stall_M, Misaligned_M, Bus_Timeout_M;
//   *_W MEM/WB register outputs feeding the writeback mux.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
)
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Valid_M,
  input  logic                 Reg_Write_M,
  input  logic [4:0]           Rd_M,
  input  logic [1:0]           Result_Src_Sel_M,
  input  logic                 Mem_Read_M,
  input  logic                 Mem_Write_M,
  input  logic [2:0]           Funct3_M,
  input  logic [31:0]          ALU_Out_M,
  input  logic [31:0]          Store_Data_M,
  input  logic [31:0]          PC_Plus_4_M,
  memory_stage_if.master       dmem,
  output logic                 Stall_M,
  output logic                 Misaligned_M,
  output logic                 Bus_Timeout_M,
  output logic                 Valid_W,
  output logic                 Reg_Write_W,
  output logic [4:0]           Rd_W,
  output logic [1:0]           Result_Src_Sel_W,
  output logic [31:0]          ALU_Out_W,
  output logic [31:0]          Data_Out_Ext_W,
  output logic [31:0]          PC_Plus_4_W
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  mem_state_t  state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;

  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic        timeout_now;
  logic        stall_raw;
  logic        fault_mis;
  logic        fault_to;
  logic        w_take;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] load_ext;

  load_store_align u_align (
    .mem_read   (Mem_Read_M),
    .mem_write  (Mem_Write_M),
    .funct3     (Funct3_M),
    .addr_lo    (ALU_Out_M[1:0]),
    .store_data (Store_Data_M),
    .rdata      (dmem.DMem_Rdata),
    .byte_en    (byte_en),
    .wdata      (wdata),
    .misaligned (misaligned),
    .load_ext   (load_ext)
  );

  assign mem_op = Valid_M & (Mem_Read_M | Mem_Write_M);
  assign access = mem_op & ~misaligned;

  // Ready arriving on the last tolerated cycle still completes the access.
  assign timeout_now = (state == MEM_WAIT) && (wait_cnt == MAX_WAIT_C) &&
                       !dmem.DMem_Ready;

  assign stall_raw = access & ~dmem.DMem_Ready & ~timeout_now;
  assign fault_mis = mem_op & misaligned;
  assign fault_to  = access & timeout_now;

  // Reset abandons an outstanding access in the same cycle, so every
  // request/fault/stall output is gated by RST combinationally.
  assign dmem.DMem_Req      = access & ~timeout_now & ~RST;
  assign dmem.DMem_We       = access & ~timeout_now & ~RST &
                              Mem_Write_M & ~Mem_Read_M;
  assign dmem.DMem_Addr     = {ALU_Out_M[31:2], 2'b00};
  assign dmem.DMem_Byte_En  = byte_en;
  assign dmem.DMem_Wdata    = wdata;

  assign Stall_M       = stall_raw & ~RST;
  assign Misaligned_M  = fault_mis & ~RST;
  assign Bus_Timeout_M = fault_to & ~RST;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= MEM_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      MEM_IDLE: begin
        if (access && !dmem.DMem_Ready) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        // Leaving on !access is defensive: upstream is held while stalled.
        if (!access || dmem.DMem_Ready || timeout_now) begin
          state_nxt    = MEM_IDLE;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt != 8'hFF) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = MEM_IDLE;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // ------------------------------------------------------ MEM/WB register
  // Anything that is not a completed instruction enters W as a bubble.
  assign w_take = Valid_M & ~stall_raw & ~fault_mis & ~fault_to;

  always_ff @(posedge CLK) begin
    if (RST || !w_take) begin
      Valid_W          <= 1'b0;
      Reg_Write_W      <= 1'b0;
      Rd_W             <= 5'd0;
      Result_Src_Sel_W <= RESULT_ALU;
      ALU_Out_W        <= 32'd0;
      Data_Out_Ext_W   <= 32'd0;
      PC_Plus_4_W      <= 32'd0;
    end else begin
      Valid_W          <= 1'b1;
      Reg_Write_W      <= Reg_Write_M;
      Rd_W             <= Rd_M;
      Result_Src_Sel_W <= Result_Src_Sel_M;
      ALU_Out_W        <= ALU_Out_M;
      // Reaching here with a load means DMem_Ready was high this cycle.
      Data_Out_Ext_W   <= Mem_Read_M ? load_ext : 32'd0;
      PC_Plus_4_W      <= PC_Plus_4_M;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed table of single-cycle accesses plus hand-written
// wait-state, timeout and reset-during-wait sequences for memory_stage.
// Ports: none (top-level bench); DUT built with MAX_WAIT = 4.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Valid_M, Reg_Write_M, Mem_Read_M, Mem_Write_M;
  logic [4:0]  Rd_M;
  logic [1:0]  Result_Src_Sel_M;
  logic [2:0]  Funct3_M;
  logic [31:0] ALU_Out_M, Store_Data_M, PC_Plus_4_M;
  logic        Stall_M, Misaligned_M, Bus_Timeout_M;
  logic        Valid_W, Reg_Write_W;
  logic [4:0]  Rd_W;
  logic [1:0]  Result_Src_Sel_W;
  logic [31:0] ALU_Out_W, Data_Out_Ext_W, PC_Plus_4_W;

  memory_stage_if dmem();

  memory_stage #(.MAX_WAIT(4)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .Valid_M          (Valid_M),
    .Reg_Write_M      (Reg_Write_M),
    .Rd_M             (Rd_M),
    .Result_Src_Sel_M (Result_Src_Sel_M),
    .Mem_Read_M       (Mem_Read_M),
    .Mem_Write_M      (Mem_Write_M),
    .Funct3_M         (Funct3_M),
    .ALU_Out_M        (ALU_Out_M),
    .Store_Data_M     (Store_Data_M),
    .PC_Plus_4_M      (PC_Plus_4_M),
    .dmem             (dmem),
    .Stall_M          (Stall_M),
    .Misaligned_M     (Misaligned_M),
    .Bus_Timeout_M    (Bus_Timeout_M),
    .Valid_W          (Valid_W),
    .Reg_Write_W      (Reg_Write_W),
    .Rd_W             (Rd_W),
    .Result_Src_Sel_W (Result_Src_Sel_W),
    .ALU_Out_W        (ALU_Out_W),
    .Data_Out_Ext_W   (Data_Out_Ext_W),
    .PC_Plus_4_W      (PC_Plus_4_W)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid, rdm, wrm, regw;
    logic [4:0]  rd;
    logic [1:0]  rss;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, pc4, rdata;
    logic        e_req, e_we, e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_vw, e_rww;
    logic [31:0] e_dext;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic valid, rdm, wrm, regw, input logic [4:0] rd, input logic [1:0] rss,
    input logic [2:0] f3, input logic [31:0] addr, sdata, pc4, rdata,
    input logic e_req, e_we, e_mis, input logic [3:0] e_be, input logic [31:0] e_wdata,
    input logic e_vw, e_rww, input logic [31:0] e_dext);
    vec_t v;
    v.valid = valid; v.rdm = rdm; v.wrm = wrm; v.regw = regw; v.rd = rd; v.rss = rss;
    v.f3 = f3; v.addr = addr; v.sdata = sdata; v.pc4 = pc4; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_mis = e_mis; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_vw = e_vw; v.e_rww = e_rww; v.e_dext = e_dext;
    return v;
  endfunction

  task automatic set_in(input logic valid, rdm, wrm, regw, input logic [4:0] rd,
                        input logic [1:0] rss, input logic [2:0] f3,
                        input logic [31:0] addr, sdata, pc4);
    Valid_M = valid; Mem_Read_M = rdm; Mem_Write_M = wrm; Reg_Write_M = regw;
    Rd_M = rd; Result_Src_Sel_M = rss; Funct3_M = f3;
    ALU_Out_M = addr; Store_Data_M = sdata; PC_Plus_4_M = pc4;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, " Valid_W"}, Valid_W, 0);
    chk({tag, " Reg_Write_W"}, Reg_Write_W, 0);
    chk({tag, " Rd_W"}, Rd_W, 0);
    chk({tag, " Result_Src_Sel_W"}, Result_Src_Sel_W, RESULT_ALU);
    chk({tag, " ALU_Out_W"}, ALU_Out_W, 0);
    chk({tag, " Data_Out_Ext_W"}, Data_Out_Ext_W, 0);
    chk({tag, " PC_Plus_4_W"}, PC_Plus_4_W, 0);
  endtask

  initial begin
    // Table: all with DMem_Ready = 1.
    vecs.push_back(mk(1,1,0,1,5,RESULT_MEM,F3_B, 32'h103,0,32'h108,32'h8000_0000, 1,0,0,4'b1000,0, 1,1,32'hFFFF_FF80));
    vecs.push_back(mk(1,1,0,1,5,RESULT_MEM,F3_BU,32'h103,0,32'h108,32'h8000_0000, 1,0,0,4'b1000,0, 1,1,32'h0000_0080));
    vecs.push_back(mk(1,0,1,0,0,RESULT_ALU,F3_H, 32'h202,32'h1234_ABCD,32'h20C,0, 1,1,0,4'b1100,32'hABCD_ABCD, 1,0,0));
    vecs.push_back(mk(1,1,0,1,9,RESULT_MEM,F3_W, 32'h301,0,32'h310,32'hFFFF_FFFF, 0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,1,7,RESULT_ALU,3'b000,32'h55,0,32'h400,0, 0,0,0,0,0, 1,1,0));
    vecs.push_back(mk(1,1,0,1,3,RESULT_MEM,F3_H, 32'h102,0,32'h110,32'h8001_7FFF, 1,0,0,4'b1100,0, 1,1,32'hFFFF_8001));
    vecs.push_back(mk(1,1,0,1,3,RESULT_MEM,F3_HU,32'h102,0,32'h110,32'h8001_7FFF, 1,0,0,4'b1100,0, 1,1,32'h0000_8001));
    vecs.push_back(mk(1,0,1,0,0,RESULT_ALU,F3_B, 32'h101,32'h1234_56A5,32'h114,0, 1,1,0,4'b0010,32'hA5A5_A5A5, 1,0,0));
    vecs.push_back(mk(1,0,1,0,0,RESULT_ALU,F3_W, 32'h400,32'hDEAD_BEEF,32'h118,0, 1,1,0,4'b1111,32'hDEAD_BEEF, 1,0,0));
    vecs.push_back(mk(1,1,0,1,6,RESULT_MEM,F3_H, 32'h103,0,32'h11C,32'h1111_1111, 0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,1,6,RESULT_MEM,3'b011,32'h100,0,32'h120,32'h2222_2222, 0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,1,0,0,RESULT_ALU,3'b100,32'h100,32'h3333_3333,32'h124,0, 0,0,1,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,1,8,RESULT_MEM,F3_W, 32'h100,0,32'h128,32'h4444_4444, 0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,1,1,RESULT_PC4,3'b000,32'h9999,0,32'h1004,0, 0,0,0,0,0, 1,1,0));
    vecs.push_back(mk(1,1,0,1,2,RESULT_MEM,F3_B, 32'h100,0,32'h12C,32'h1234_567F, 1,0,0,4'b0001,0, 1,1,32'h0000_007F));
    vecs.push_back(mk(1,1,0,1,2,RESULT_MEM,F3_HU,32'h100,0,32'h130,32'hFFFF_8001, 1,0,0,4'b0011,0, 1,1,32'h0000_8001));
    vecs.push_back(mk(1,1,0,1,2,RESULT_MEM,F3_B, 32'h102,0,32'h134,32'h00FE_0000, 1,0,0,4'b0100,0, 1,1,32'hFFFF_FFFE));

    // Reset with a stalling load presented: outputs must stay quiet.
    RST = 1'b1;
    set_in(1,1,0,1,4,RESULT_MEM,F3_W,32'h300,0,32'h304);
    dmem.DMem_Ready = 1'b0;
    dmem.DMem_Rdata = 32'd0;
    tick();
    @(negedge CLK);
    chk("rst DMem_Req", dmem.DMem_Req, 0);
    chk("rst Stall_M", Stall_M, 0);
    chk("rst Misaligned_M", Misaligned_M, 0);
    chk("rst Bus_Timeout_M", Bus_Timeout_M, 0);
    tick();
    chk_w_zero("rst");
    RST = 1'b0;

    foreach (vecs[i]) begin
      set_in(vecs[i].valid, vecs[i].rdm, vecs[i].wrm, vecs[i].regw, vecs[i].rd,
             vecs[i].rss, vecs[i].f3, vecs[i].addr, vecs[i].sdata, vecs[i].pc4);
      dmem.DMem_Ready = 1'b1;
      dmem.DMem_Rdata = vecs[i].rdata;
      @(negedge CLK);
      chk($sformatf("v%0d DMem_Req", i), dmem.DMem_Req, vecs[i].e_req);
      chk($sformatf("v%0d Stall_M", i), Stall_M, 0);
      chk($sformatf("v%0d Misaligned_M", i), Misaligned_M, vecs[i].e_mis);
      chk($sformatf("v%0d Bus_Timeout_M", i), Bus_Timeout_M, 0);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d DMem_Addr", i), dmem.DMem_Addr, vecs[i].addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d DMem_Byte_En", i), dmem.DMem_Byte_En, vecs[i].e_be);
        chk($sformatf("v%0d DMem_We", i), dmem.DMem_We, vecs[i].e_we);
        if (vecs[i].e_we)
          chk($sformatf("v%0d DMem_Wdata", i), dmem.DMem_Wdata, vecs[i].e_wdata);
      end
      tick();
      chk($sformatf("v%0d Valid_W", i), Valid_W, vecs[i].e_vw);
      chk($sformatf("v%0d Reg_Write_W", i), Reg_Write_W, vecs[i].e_rww);
      chk($sformatf("v%0d Data_Out_Ext_W", i), Data_Out_Ext_W, vecs[i].e_dext);
      chk($sformatf("v%0d Rd_W", i), Rd_W, vecs[i].e_vw ? vecs[i].rd : 5'd0);
      chk($sformatf("v%0d Result_Src_Sel_W", i), Result_Src_Sel_W, vecs[i].e_vw ? vecs[i].rss : RESULT_ALU);
      chk($sformatf("v%0d ALU_Out_W", i), ALU_Out_W, vecs[i].e_vw ? vecs[i].addr : 32'd0);
      chk($sformatf("v%0d PC_Plus_4_W", i), PC_Plus_4_W, vecs[i].e_vw ? vecs[i].pc4 : 32'd0);
    end

    // LW with three wait states.
    set_in(1,1,0,1,10,RESULT_MEM,F3_W,32'h300,0,32'h304);
    dmem.DMem_Ready = 1'b0;
    dmem.DMem_Rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("ws%0d Stall_M", k), Stall_M, 1);
      chk($sformatf("ws%0d DMem_Req", k), dmem.DMem_Req, 1);
      chk($sformatf("ws%0d DMem_Addr", k), dmem.DMem_Addr, 32'h300);
      tick();
      chk($sformatf("ws%0d Valid_W", k), Valid_W, 0);
      chk($sformatf("ws%0d Reg_Write_W", k), Reg_Write_W, 0);
    end
    dmem.DMem_Ready = 1'b1;
    @(negedge CLK);
    chk("ws done Stall_M", Stall_M, 0);
    chk("ws done DMem_Req", dmem.DMem_Req, 1);
    tick();
    chk("ws done Valid_W", Valid_W, 1);
    chk("ws done Reg_Write_W", Reg_Write_W, 1);
    chk("ws done Rd_W", Rd_W, 10);
    chk("ws done Data_Out_Ext_W", Data_Out_Ext_W, 32'hCAFE_F00D);

    // Timeout: MAX_WAIT = 4, ready never comes.
    set_in(1,1,0,1,11,RESULT_MEM,F3_W,32'h300,0,32'h304);
    dmem.DMem_Ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("to%0d Stall_M", k), Stall_M, 1);
      chk($sformatf("to%0d DMem_Req", k), dmem.DMem_Req, 1);
      chk($sformatf("to%0d Bus_Timeout_M", k), Bus_Timeout_M, 0);
      tick();
    end
    @(negedge CLK);
    chk("to end DMem_Req", dmem.DMem_Req, 0);
    chk("to end Stall_M", Stall_M, 0);
    chk("to end Bus_Timeout_M", Bus_Timeout_M, 1);
    tick();
    chk("to end Valid_W", Valid_W, 0);
    chk("to end Reg_Write_W", Reg_Write_W, 0);
    set_in(1,0,0,1,12,RESULT_ALU,3'b000,32'h55,0,32'h500);
    @(negedge CLK);
    chk("to next Bus_Timeout_M", Bus_Timeout_M, 0);
    chk("to next Stall_M", Stall_M, 0);
    tick();
    chk("to next Valid_W", Valid_W, 1);
    chk("to next ALU_Out_W", ALU_Out_W, 32'h55);

    // Reset while waiting on a load.
    set_in(1,1,0,1,13,RESULT_MEM,F3_W,32'h300,0,32'h304);
    dmem.DMem_Ready = 1'b0;
    @(negedge CLK);
    chk("rw pre Stall_M", Stall_M, 1);
    tick();
    @(negedge CLK);
    chk("rw wait Stall_M", Stall_M, 1);
    RST = 1'b1;
    #1;
    chk("rw rst DMem_Req", dmem.DMem_Req, 0);
    chk("rw rst Stall_M", Stall_M, 0);
    tick();
    chk_w_zero("rw");
    RST = 1'b0;
    set_in(1,0,0,1,4,RESULT_ALU,3'b000,32'h55,0,32'h600);
    @(negedge CLK);
    chk("rw alu DMem_Req", dmem.DMem_Req, 0);
    chk("rw alu Stall_M", Stall_M, 0);
    tick();
    chk("rw alu Valid_W", Valid_W, 1);
    chk("rw alu Rd_W", Rd_W, 4);
    chk("rw alu ALU_Out_W", ALU_Out_W, 32'h55);
    // From IDLE a ready load completes with zero latency.
    set_in(1,1,0,1,14,RESULT_MEM,F3_W,32'h308,0,32'h604);
    dmem.DMem_Ready = 1'b1;
    dmem.DMem_Rdata = 32'h0000_0011;
    @(negedge CLK);
    chk("rw ld Stall_M", Stall_M, 0);
    chk("rw ld DMem_Req", dmem.DMem_Req, 1);
    tick();
    chk("rw ld Valid_W", Valid_W, 1);
    chk("rw ld Data_Out_Ext_W", Data_Out_Ext_W, 32'h0000_0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory (M) stage of the RV32i pipeline.
- Issues byte-enabled load/store requests to data memory, waiting through wait states with a ready handshake.
- Sign- or zero-extends load data and holds the MEM/WB pipeline register that drives the writeback result mux.
- Stalls upstream stages while a data-memory access is outstanding. Flags misaligned and timed-out accesses.

Parameters:
- MAX_WAIT, 255, wait cycles tolerated before an access is aborted as timed out (range 1..255).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- Valid_M  in  1  M-stage instruction valid
- Reg_Write_M  in  1  register-file write enable
- Rd_M  in  5  destination register
- Result_Src_Sel_M  in  2  RESULT_ALU / RESULT_MEM / RESULT_PC4
- Mem_Read_M  in  1  load
- Mem_Write_M  in  1  store
- Funct3_M  in  3  access size and sign
- ALU_Out_M  in  32  effective address or ALU result
- Store_Data_M  in  32  rs2 value
- PC_Plus_4_M  in  32  link value
- DMem_Req  out  1  request
- DMem_We  out  1  write
- DMem_Addr  out  32  word address, bits [1:0] = 0
- DMem_Byte_En  out  4  lane enables
- DMem_Wdata  out  32  lane-replicated store data
- DMem_Ready  in  1  access completes this cycle; DMem_Rdata valid
- DMem_Rdata  in  32  read word
- Stall_M  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- Misaligned_M  out  1  one-cycle fault pulse
- Bus_Timeout_M  out  1  one-cycle fault pulse
- Valid_W, Reg_Write_W  out  1 each
- Rd_W  out  5
- Result_Src_Sel_W  out  2
- ALU_Out_W, Data_Out_Ext_W, PC_Plus_4_W  out  32 each

Behaviour:
- Access condition: Access = Valid_M & (Mem_Read_M | Mem_Write_M) & aligned & legal Funct3.
- Legal Funct3 for loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal for stores: SB 000, SH 001, SW 010.
- Alignment:
  - Halfword is misaligned if addr[0] = 1.
  - Word is misaligned if addr[1:0] ≠ 0.
  - An illegal Funct3 is treated as misaligned.
- Misaligned access: no request is issued. Misaligned_M = 1 for that cycle. The W register captures a bubble.
- DMem_Req = Access, combinational, and is held while waiting. All inputs are stable during a stall because upstream is held.
- Byte enables by addr[1:0]:
  - Byte: 0001 << a.
  - Half: 0011 << a.
  - Word: 1111.
- Store data replication:
  - SB: byte ×4.
  - SH: half ×2.
  - SW: as is.
- FSM states: IDLE, WAIT.
  - IDLE with Access and DMem_Ready: access completes this cycle, no stall, zero latency.
  - IDLE with Access and !DMem_Ready: go to WAIT, Wait_Cnt = 1.
  - WAIT with DMem_Ready: return to IDLE, access completes.
  - WAIT with Wait_Cnt == MAX_WAIT: go to IDLE, DMem_Req = 0 in that cycle, Bus_Timeout_M = 1, W captures a bubble.
  - Otherwise in WAIT: Wait_Cnt increments (8-bit, saturating).
- Stall_M = Access & !DMem_Ready & !timeout_now.
- W register update:
  - While Stall_M = 1, W captures a bubble: Valid_W = 0, Reg_Write_W = 0, Result_Src_Sel_W = RESULT_ALU, data fields 0.
  - Otherwise W captures the M fields.
  - A non-memory instruction passes through in one cycle.
- Load extension uses the lane selected by addr[1:0]:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: word as is.
  - Registered into Data_Out_Ext_W on completion.
  - Stores and non-memory instructions set Data_Out_Ext_W = 0.
- Faulting or timed-out instructions set Reg_Write_W = 0 and Valid_W = 0.
- Reset: all W outputs 0, Result_Src_Sel_W = RESULT_ALU, state IDLE, Wait_Cnt 0, fault pulses 0.
  - Reset during WAIT abandons the access; DMem_Req drops in the same cycle RST is high.
- Valid_M = 0 means no request, no faults, and a bubble to W.

Decomposition:
- Shared package definitions gets:
  - the existing RESULT_* encodings, reused;
  - new funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - mem_state_t enum {MEM_IDLE, MEM_WAIT}.
- Sub-module load_store_align: purely combinational. Computes byte enables, write data and the misaligned flag, and extends load data.
- memory_stage keeps the FSM, the wait counter and the W register.

Test Plan:
- LB at 0x103 with DMem_Rdata = 0x80_00_00_00 and Ready = 1: Byte_En = 1000, no stall; next cycle Data_Out_Ext_W = 0xFFFF_FF80, Reg_Write_W = 1. Repeat with LBU: result 0x0000_0080.
- SH at 0x202, Store_Data = 0x1234_ABCD: DMem_Addr = 0x200, Byte_En = 1100, Wdata = 0xABCD_ABCD, We = 1; W has Reg_Write_W = 0.
- LW at 0x300 with Ready low for 3 cycles: Stall_M high for exactly 3 cycles with Req held; W gets 3 bubbles, then Data_Out_Ext_W = Rdata and Valid_W = 1.
- LW at 0x301: no DMem_Req, Misaligned_M pulses 1 cycle, next Valid_W = 0, Reg_Write_W = 0.
- MAX_WAIT = 4, Ready never asserted: Stall_M for 4 cycles, then Req drops, Bus_Timeout_M pulses, bubble in W, pipeline resumes.
- RST asserted during WAIT: same-cycle Req = 0 and Stall_M = 0; next cycle all W outputs 0, state IDLE. A following ALU instruction (ALU_Out_M = 0x55) reaches ALU_Out_W one cycle later.
